// File: rtl/apb_req_arbiter_pkg.sv
// Shared types and default widths for apb_req_arbiter and its round-robin picker.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package apb_arb_pkg;

  localparam int unsigned NUM_REQ_DEFAULT = 4;
  localparam int unsigned IDX_W = $clog2(NUM_REQ_DEFAULT);

  typedef enum logic [1:0] {
    ARB_IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_req_arbiter_if.sv
// Arbiter <-> apb_master/slave signal bundle; master modport is the arbiter side.
interface apb_req_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = `ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = `DATA_WIDTH
);
  logic                  transfer;
  logic                  READ_WRITE;
  logic [ADDR_WIDTH-1:0] apb_wr_addr;
  logic [ADDR_WIDTH-1:0] apb_rd_addr;
  logic [DATA_WIDTH-1:0] apb_wr_data;
  logic                  PSELx;
  logic                  PENABLE;
  logic                  PREADY;
  logic                  PSLVERR;
  logic [DATA_WIDTH-1:0] PRDATA;

  modport master (
    output transfer, READ_WRITE, apb_wr_addr, apb_rd_addr, apb_wr_data,
    input  PSELx, PENABLE, PREADY, PSLVERR, PRDATA
  );

  modport slave (
    input  transfer, READ_WRITE, apb_wr_addr, apb_rd_addr, apb_wr_data,
    output PSELx, PENABLE, PREADY, PSLVERR, PRDATA
  );
endinterface

// File: rtl/apb_req_arbiter_rr_arbiter.sv
// Combinational winner picker: round-robin from ptr, or lowest index wins when
// APB_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEFAULT,
  parameter int unsigned IdxW    = IDX_W
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdxW-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IdxW-1:0]    idx
);

`ifdef APB_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Scan downwards so the lowest requesting index is written last.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req[IdxW'(i)]) begin
        grant            = '0;
        grant[IdxW'(i)]  = 1'b1;
        idx              = IdxW'(i);
      end
    end
  end
`else
  always_comb begin
    int unsigned c;
    logic        found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      c = 32'(ptr) + i;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!found && req[IdxW'(c)]) begin
        found            = 1'b1;
        grant[IdxW'(c)]  = 1'b1;
        idx              = IdxW'(c);
      end
    end
  end
`endif

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one apb_master among NUM_REQ requesters, one transfer outstanding at a time.
// APB_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = `ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  apb_req_arbiter_if.master             apb
);

  localparam int unsigned IdxW = idx_width(NUM_REQ);

  arb_state_e             state_q, state_d;
  logic [IdxW-1:0]        ptr_q;
  logic [IdxW-1:0]        winner_q, winner_d;
  logic                   transfer_q, transfer_d;
  logic                   rw_q, rw_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic [NUM_REQ-1:0]     req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ-1:0]     grant;
  logic [IdxW-1:0]        win_idx;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IdxW    (IdxW)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (win_idx)
  );

`ifdef APB_ARB_FIXED_PRIO_EN
  assign ptr_q = '0;
`else
  logic [IdxW-1:0] ptr_d;
`endif

  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    transfer_d  = transfer_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
`ifndef APB_ARB_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`endif
    unique case (state_q)
      ARB_IDLE: begin
        if (|req_valid) begin
          req_ready_d = grant;
          winner_d    = win_idx;
          rw_d        = req_write[win_idx];
          addr_d      = req_addr[32'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d     = req_wdata[32'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
          transfer_d  = 1'b1;
          state_d     = ISSUE;
`ifndef APB_ARB_FIXED_PRIO_EN
          ptr_d = (win_idx == IdxW'(NUM_REQ - 1)) ? '0 : win_idx + IdxW'(1);
`endif
        end
      end
      // Drop transfer once the master is in SETUP so it returns to IDLE after ACCESS.
      ISSUE: begin
        if (apb.PSELx && !apb.PENABLE) begin
          transfer_d = 1'b0;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (apb.PSELx && apb.PENABLE && apb.PREADY) begin
          if (!rw_q) rdata_d = apb.PRDATA;
          err_d                 = apb.PSLVERR;
          rsp_valid_d[winner_q] = 1'b1;
          state_d               = RESP;
        end
      end
      RESP: begin
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= ARB_IDLE;
      winner_q    <= '0;
      transfer_q  <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      transfer_q  <= transfer_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

`ifndef APB_ARB_FIXED_PRIO_EN
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end
`endif

  assign req_ready       = req_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_rdata       = rdata_q;
  assign rsp_err         = err_q;
  assign apb.transfer    = transfer_q;
  assign apb.READ_WRITE  = rw_q;
  assign apb.apb_wr_addr = addr_q;
  assign apb.apb_rd_addr = addr_q;
  assign apb.apb_wr_data = wdata_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter with behavioural apb_master/slave and request model.
module tb_apb_req_arbiter;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  logic [NR-1:0]    req_valid, req_write, req_ready, rsp_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_err;

  apb_req_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

  apb_req_arbiter #(
    .NUM_REQ    (NR),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .apb       (apb)
  );

  // apb_master (0 idle, 1 setup, 2 access) plus a slave with programmable wait states.
  int          mst_state;
  int          wait_cnt;
  int          slv_waits;
  logic        slv_err;
  logic [31:0] slv_rdata;

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      mst_state <= 0;
      wait_cnt  <= 0;
    end else begin
      case (mst_state)
        0: if (apb.transfer) mst_state <= 1;
        1: mst_state <= 2;
        default: begin
          if (apb.PREADY) begin
            mst_state <= apb.transfer ? 1 : 0;
            wait_cnt  <= 0;
          end else begin
            wait_cnt <= wait_cnt + 1;
          end
        end
      endcase
    end
  end

  assign apb.PSELx   = (mst_state != 0);
  assign apb.PENABLE = (mst_state == 2);
  assign apb.PREADY  = (mst_state == 2) && (wait_cnt >= slv_waits);
  assign apb.PSLVERR = apb.PREADY && slv_err;
  assign apb.PRDATA  = slv_rdata;

  // Requester-side model state.
  bit          pv[NR];
  bit          pw[NR];
  bit          hold[NR];
  logic [31:0] pa[NR];
  logic [31:0] pd[NR];
  int          m_ptr;
  logic [31:0] m_rdata;
  int          checks;
  int          failures;

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]           = pv[i];
      req_write[i]           = pw[i];
      req_addr[i*AW +: AW]   = pa[i];
      req_wdata[i*DW +: DW]  = pd[i];
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d);
    pv[i] = 1'b1;
    pw[i] = wr;
    pa[i] = a;
    pd[i] = d;
  endtask

  // Entered at the negedge before the ARB_IDLE sampling edge; leaves at the same point.
  task automatic run_one(input int waits, input bit err, input logic [31:0] rdata,
                         input int raise_id);
    int          w;
    int          c;
    int          cyc;
    bit          stable;
    logic [31:0] ea;
    bit          ew;
    w = -1;
    for (int i = 0; i < NR; i++) begin
`ifdef APB_ARB_FIXED_PRIO_EN
      c = i;
`else
      c = (m_ptr + i) % NR;
`endif
      if (w < 0 && pv[c]) w = c;
    end
    if (w < 0) return;
    slv_waits = waits;
    slv_err   = err;
    slv_rdata = rdata;
    @(negedge PCLK);
    chk("req_ready", req_ready, 64'(1 << w));
    chk("transfer", apb.transfer, 1);
    chk("read_write", apb.READ_WRITE, pw[w]);
    chk("wr_addr", apb.apb_wr_addr, pa[w]);
    chk("rd_addr", apb.apb_rd_addr, pa[w]);
    if (pw[w]) chk("wr_data", apb.apb_wr_data, pd[w]);
    ea    = pa[w];
    ew    = pw[w];
    m_ptr = (w + 1) % NR;
    if (!hold[w]) pv[w] = 1'b0;
    if (raise_id >= 0) pv[raise_id] = 1'b1;
    drive();
    cyc    = 0;
    stable = 1'b1;
    do begin
      @(negedge PCLK);
      cyc++;
      if (apb.apb_rd_addr !== ea || apb.READ_WRITE !== ew || req_ready !== '0) stable = 1'b0;
    end while (rsp_valid === '0 && cyc < 40);
    chk("latency", cyc, 3 + waits);
    chk("hold_stable", stable, 1);
    chk("rsp_valid", rsp_valid, 64'(1 << w));
    chk("rsp_err", rsp_err, err);
    if (!ew) m_rdata = rdata;
    chk("rsp_rdata", rsp_rdata, m_rdata);
    @(negedge PCLK);
    chk("rsp_pulse", rsp_valid, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_transfer"}, apb.transfer, 0);
    chk({tag, "_rw"}, apb.READ_WRITE, 0);
    chk({tag, "_wr_addr"}, apb.apb_wr_addr, 0);
    chk({tag, "_rd_addr"}, apb.apb_rd_addr, 0);
    chk({tag, "_wr_data"}, apb.apb_wr_data, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
  endtask

  initial begin
    bit any;
    int quiet;
    checks    = 0;
    failures  = 0;
    m_ptr     = 0;
    m_rdata   = '0;
    slv_waits = 0;
    slv_err   = 1'b0;
    slv_rdata = '0;
    for (int i = 0; i < NR; i++) begin
      pv[i] = 0; pw[i] = 0; hold[i] = 0; pa[i] = '0; pd[i] = '0;
    end
    drive();
    repeat (3) @(negedge PCLK);
    chk_all_zero("reset");
    PRESETn = 1'b1;
    @(negedge PCLK);

    // All four requesters held valid: round-robin order 0,1,2,3,0.
    for (int i = 0; i < NR; i++) begin
      set_req(i, i[0], 32'h100 + 32'(i) * 4, 32'hC0DE_0000 + 32'(i));
      hold[i] = 1'b1;
    end
    drive();
    for (int k = 0; k < 5; k++) run_one(k % 2, 1'b0, 32'h1111_0000 + 32'(k), -1);
    for (int i = 0; i < NR; i++) begin
      pv[i] = 0; hold[i] = 0;
    end
    drive();

    // Single write, single read with 3 wait states, error read, then a normal write.
    set_req(0, 1'b1, 32'h10, 32'hA5A5_0001);
    drive();
    run_one(0, 1'b0, 32'h0, -1);
    set_req(2, 1'b0, 32'h20, 32'h0);
    drive();
    run_one(3, 1'b0, 32'hDEAD_BEEF, -1);
    set_req(1, 1'b0, 32'hFFFF_F000, 32'h0);
    drive();
    run_one(1, 1'b1, 32'h5555_AAAA, -1);
    chk("mst_idle_after_err", mst_state, 0);
    set_req(0, 1'b1, 32'h44, 32'h1234_5678);
    drive();
    run_one(0, 1'b0, 32'h0, -1);

    // Requester 3 raises while requester 1 is in flight; it wins the next ARB_IDLE.
    set_req(1, 1'b1, 32'h30, 32'h0BAD_F00D);
    pa[3] = 32'h3C; pw[3] = 1'b0; pd[3] = '0;
    drive();
    run_one(2, 1'b0, 32'h0, 3);
    run_one(0, 1'b0, 32'h7777_8888, -1);

    // Reset during WAIT: outputs clear, no response, pointer back to 0.
    set_req(2, 1'b1, 32'h200, 32'hFEED_0002);
    drive();
    slv_waits = 6;
    slv_err   = 1'b0;
    @(negedge PCLK);
    chk("rst_pre_ready", req_ready, 4'b0100);
    pv[2] = 0;
    drive();
    repeat (4) @(negedge PCLK);
    chk("rst_pre_access", apb.PENABLE, 1);
    PRESETn = 1'b0;
    #1;
    chk_all_zero("async_rst");
    m_ptr   = 0;
    m_rdata = '0;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    quiet = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge PCLK);
      if (rsp_valid !== '0 || apb.transfer !== 1'b0) quiet++;
    end
    chk("no_rsp_after_reset", quiet, 0);
    set_req(1, 1'b0, 32'h50, 32'h0);
    set_req(3, 1'b1, 32'h58, 32'h0303_0303);
    drive();
    run_one(0, 1'b0, 32'h9999_0001, -1);
    run_one(1, 1'b0, 32'h0, -1);

    // Randomized traffic against the model.
    for (int it = 0; it < 24; it++) begin
      any = 1'b0;
      for (int i = 0; i < NR; i++) begin
        if (!pv[i] && $urandom_range(0, 2) == 0)
          set_req(i, 1'($urandom), $urandom, $urandom);
        if (pv[i]) any = 1'b1;
      end
      if (!any) set_req(int'($urandom_range(0, NR - 1)), 1'($urandom), $urandom, $urandom);
      drive();
      run_one(int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), $urandom, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
